// File: rtl/disp_demux.sv
// disp_demux: captures a multiplexed, active-low 3-digit 7-segment scan bus
// into three stable, active-high digit registers.
// The bus and enables pass through two flop stages before any use.
// A digit is captured once {en,sseg} has held for STABLE_CYC consecutive samples.
// After a capture, further capture waits until the enables change.
// Optional build macro DISP_DEMUX_DECODE_EN adds hex0..hex2 and dec_err.
// These decode each captured pattern to a nibble.
//
// state  | meaning
// IDLE   | no digit enabled, or an illegal enable pattern is present
// SETTLE | one digit enabled; counting identical consecutive samples
// HOLD   | digit captured; waiting for the enables to change
module disp_demux #(
    parameter int STABLE_CYC  = 4,
    parameter int TIMEOUT_CYC = 100000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] sseg,
    input  logic [2:0] en,
    output logic [7:0] out0,
    output logic [7:0] out1,
    output logic [7:0] out2,
    output logic [2:0] valid,
    output logic       frame_done,
    output logic       scan_err,
    output logic       stale
`ifdef DISP_DEMUX_DECODE_EN
    ,
    output logic [3:0] hex0,
    output logic [3:0] hex1,
    output logic [3:0] hex2,
    output logic [2:0] dec_err
`endif
);

    typedef enum logic [1:0] {IDLE, SETTLE, HOLD} state_t;

    localparam logic [7:0]  STB = 8'(STABLE_CYC);
    localparam logic [23:0] TO  = 24'(TIMEOUT_CYC);

    state_t      state, state_nx;
    logic [7:0]  s1_ss, s2_ss, pv_ss;
    logic [2:0]  s1_en, s2_en, pv_en;
    logic [7:0]  cnt, cnt_nx;
    logic [2:0]  mask;
    logic [23:0] tcnt;
    logic        take, err, eval;
    logic [2:0]  sel;

    function automatic logic one_low(input logic [2:0] e);
        return (e == 3'b110) || (e == 3'b101) || (e == 3'b011);
    endfunction

    function automatic logic bad_en(input logic [2:0] e);
        return !one_low(e) && (e != 3'b111);
    endfunction

    // input synchroniser plus one extra stage used as the "previous sample"
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_ss <= 8'hFF;
            s2_ss <= 8'hFF;
            pv_ss <= 8'hFF;
            s1_en <= 3'b111;
            s2_en <= 3'b111;
            pv_en <= 3'b111;
        end else begin
            s1_ss <= sseg;
            s2_ss <= s1_ss;
            pv_ss <= s2_ss;
            s1_en <= en;
            s2_en <= s1_en;
            pv_en <= s2_en;
        end
    end

    // next-state, settle count, capture and scan-error decisions
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        take     = 1'b0;
        err      = 1'b0;
        eval     = 1'b0;
        case (state)
            IDLE:   eval = 1'b1;
            SETTLE: begin
                if ({s2_en, s2_ss} == {pv_en, pv_ss}) begin
                    cnt_nx = cnt + 8'd1;
                end else begin
                    eval = 1'b1;
                end
            end
            HOLD:   eval = (s2_en != pv_en);
            default: eval = 1'b1;
        endcase
        if (eval) begin
            if (one_low(s2_en)) begin
                state_nx = SETTLE;
                cnt_nx   = 8'd1;
            end else begin
                state_nx = IDLE;
                cnt_nx   = 8'd0;
                // only the first cycle of an illegal pattern reports
                err      = bad_en(s2_en) && !bad_en(pv_en);
            end
        end
        // a count of 1 can already complete when STABLE_CYC is 1
        if (state_nx == SETTLE && cnt_nx == STB) begin
            take     = 1'b1;
            state_nx = HOLD;
        end
    end

    assign sel = take ? ~s2_en : 3'b000;

    // state, capture registers, frame tracking and timeout
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= 8'd0;
            out0       <= 8'h00;
            out1       <= 8'h00;
            out2       <= 8'h00;
            valid      <= 3'b000;
            mask       <= 3'b000;
            frame_done <= 1'b0;
            scan_err   <= 1'b0;
            tcnt       <= 24'd0;
        end else begin
            state      <= state_nx;
            cnt        <= cnt_nx;
            scan_err   <= err;
            frame_done <= (mask == 3'b111);
            if (sel[0]) out0 <= ~s2_ss;
            if (sel[1]) out1 <= ~s2_ss;
            if (sel[2]) out2 <= ~s2_ss;
            valid <= valid | sel;
            if (mask == 3'b111) mask <= sel;
            else                mask <= mask | sel;
            if (take)           tcnt <= 24'd0;
            else if (tcnt != TO) tcnt <= tcnt + 24'd1;
        end
    end

    assign stale = (tcnt == TO);

`ifdef DISP_DEMUX_DECODE_EN
    // {err, nibble} for an active-high gfedcba pattern
    function automatic logic [4:0] dec7(input logic [6:0] p);
        case (p)
            7'h3F: return 5'h00;
            7'h06: return 5'h01;
            7'h5B: return 5'h02;
            7'h4F: return 5'h03;
            7'h66: return 5'h04;
            7'h6D: return 5'h05;
            7'h7D: return 5'h06;
            7'h07: return 5'h07;
            7'h7F: return 5'h08;
            7'h6F: return 5'h09;
            7'h77: return 5'h0A;
            7'h7C: return 5'h0B;
            7'h39: return 5'h0C;
            7'h5E: return 5'h0D;
            7'h79: return 5'h0E;
            7'h71: return 5'h0F;
            default: return 5'h10;
        endcase
    endfunction

    logic [4:0] dec_nx;
    assign dec_nx = dec7(~s2_ss[6:0]);

    // decoded digits update on the same edge as the raw captures
    always_ff @(posedge clk) begin
        if (rst) begin
            hex0    <= 4'h0;
            hex1    <= 4'h0;
            hex2    <= 4'h0;
            dec_err <= 3'b000;
        end else begin
            if (sel[0]) begin hex0 <= dec_nx[3:0]; dec_err[0] <= dec_nx[4]; end
            if (sel[1]) begin hex1 <= dec_nx[3:0]; dec_err[1] <= dec_nx[4]; end
            if (sel[2]) begin hex2 <= dec_nx[3:0]; dec_err[2] <= dec_nx[4]; end
        end
    end
`endif

endmodule
